// File: rtl/nq_pkg.sv
// Shared NanoQuarter definitions: opcodes, instruction field layout, ALU functs.
// Used by the decode/execute stage, its forwarding mux and the ALU.
// Pure declarations, no logic state.
package nq_pkg;

  localparam int NQ_DW = 16;
  localparam int NQ_RW = 3;

  // Opcode classes
  localparam logic [1:0] OP_R  = 2'b00;
  localparam logic [1:0] OP_I  = 2'b01;
  localparam logic [1:0] OP_LD = 2'b10;
  localparam logic [1:0] OP_ST = 2'b11;

  // Field positions inside the 16-bit instruction
  localparam int OP_LSB    = 14;
  localparam int RS_LSB    = 11;
  localparam int RT_LSB    = 8;
  localparam int RD_LSB    = 5;
  localparam int SHAMT_LSB = 3;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_W     = 8;

  // ALU function codes
  localparam logic [2:0] FN_AND = 3'b000;
  localparam logic [2:0] FN_OR  = 3'b001;
  localparam logic [2:0] FN_XOR = 3'b010;
  localparam logic [2:0] FN_SLL = 3'b011;
  localparam logic [2:0] FN_SUB = 3'b100;
  localparam logic [2:0] FN_ADD = 3'b101;
  localparam logic [2:0] FN_SRL = 3'b110;
  localparam logic [2:0] FN_SRA = 3'b111;

  // Instruction view; field order matches the bit positions above
  typedef struct packed {
    logic [1:0] op;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] rd;
    logic [1:0] shamt;
    logic [2:0] funct;
  } instr_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of decode-side, register-file, forwarding and execute-side signals.
// slave = the ID/EX stage itself, master = the surrounding pipeline.
// No storage; wiring only.
interface id_ex_stage_if #(
  parameter int DW = nq_pkg::NQ_DW,
  parameter int RW = nq_pkg::NQ_RW
);
  logic [15:0]   id_instr;
  logic          id_valid;
  logic          id_stall;
  logic [RW-1:0] rf_raddr1;
  logic [RW-1:0] rf_raddr2;
  logic [DW-1:0] rf_rdata1;
  logic [DW-1:0] rf_rdata2;
  logic          exm_wen;
  logic [RW-1:0] exm_rd;
  logic [DW-1:0] exm_data;
  logic          mem_wen;
  logic [RW-1:0] mem_rd;
  logic [DW-1:0] mem_data;
  logic          hold;
  logic          flush;
  logic          ex_valid;
  logic [1:0]    ex_op;
  logic [2:0]    ex_funct;
  logic [1:0]    ex_shamt;
  logic [DW-1:0] ex_reg1data;
  logic [DW-1:0] ex_reg2data;
  logic [DW-1:0] ex_imm;
  logic [RW-1:0] ex_rd;
  logic          ex_wen;
  logic          ex_is_load;
  logic [15:0]   bubble_cnt;

  modport slave (
    input  id_instr, id_valid, rf_rdata1, rf_rdata2,
           exm_wen, exm_rd, exm_data, mem_wen, mem_rd, mem_data, hold, flush,
    output id_stall, rf_raddr1, rf_raddr2, ex_valid, ex_op, ex_funct, ex_shamt,
           ex_reg1data, ex_reg2data, ex_imm, ex_rd, ex_wen, ex_is_load, bubble_cnt
  );

  modport master (
    output id_instr, id_valid, rf_rdata1, rf_rdata2,
           exm_wen, exm_rd, exm_data, mem_wen, mem_rd, mem_data, hold, flush,
    input  id_stall, rf_raddr1, rf_raddr2, ex_valid, ex_op, ex_funct, ex_shamt,
           ex_reg1data, ex_reg2data, ex_imm, ex_rd, ex_wen, ex_is_load, bubble_cnt
  );
endinterface

// File: rtl/nq_fwd_mux.sv
// Resolves one source operand: r0, EX/MEM result, MEM/WB result, register file.
// Purely combinational, zero latency.
// No flow control; the younger in-flight result always wins.
module nq_fwd_mux #(
  parameter int DW = nq_pkg::NQ_DW,
  parameter int RW = nq_pkg::NQ_RW
) (
  input  logic [RW-1:0] addr,
  input  logic [DW-1:0] rf_data,
  input  logic          exm_wen,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          mem_wen,
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] operand
);

  // Priority select: r0 is hardwired zero, then nearest producer first
  always_comb begin
    operand = rf_data;
    if (addr == '0)
      operand = '0;
    else if (exm_wen && (exm_rd == addr))
      operand = exm_data;
    else if (mem_wen && (mem_rd == addr))
      operand = mem_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/execute pipeline register: field slicing, operand forwarding, load-use bubble.
// Latency 1 cycle from id_instr to ex_* outputs.
// hold freezes every register; a load-use hazard raises id_stall and inserts one bubble.
module id_ex_stage
  import nq_pkg::*;
#(
  parameter int DW = NQ_DW,
  parameter int RW = NQ_RW
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  instr_t        ins;
  logic [RW-1:0] dest;
  logic          wen_c;
  logic          hazard;
  logic          kill;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;

  logic          ex_valid_q;
  logic [1:0]    ex_op_q;
  logic [2:0]    ex_funct_q;
  logic [1:0]    ex_shamt_q;
  logic [DW-1:0] ex_r1_q;
  logic [DW-1:0] ex_r2_q;
  logic [DW-1:0] ex_imm_q;
  logic [RW-1:0] ex_rd_q;
  logic          ex_wen_q;
  logic          ex_ld_q;
  logic [15:0]   bcnt_q;

  assign ins           = bus.id_instr;
  assign bus.rf_raddr1 = ins.rs;
  assign bus.rf_raddr2 = ins.rt;

  // Destination select and write enable; stores/branches and r0 never write
  always_comb begin
    dest  = (ins.op == OP_R) ? ins.rd : ins.rt;
    wen_c = (ins.op != OP_ST) && (dest != '0);
  end

  // A load in EX cannot forward yet; rt is treated as a source for every op class
  assign hazard = ex_valid_q && ex_ld_q && ex_wen_q && bus.id_valid &&
                  ((ex_rd_q == ins.rs) || (ex_rd_q == ins.rt));
  assign bus.id_stall = hazard || bus.hold;
  assign kill = bus.flush || hazard || !bus.id_valid;

  nq_fwd_mux #(.DW(DW), .RW(RW)) u_fwd1 (
    .addr(ins.rs), .rf_data(bus.rf_rdata1),
    .exm_wen(bus.exm_wen), .exm_rd(bus.exm_rd), .exm_data(bus.exm_data),
    .mem_wen(bus.mem_wen), .mem_rd(bus.mem_rd), .mem_data(bus.mem_data),
    .operand(op1)
  );

  nq_fwd_mux #(.DW(DW), .RW(RW)) u_fwd2 (
    .addr(ins.rt), .rf_data(bus.rf_rdata2),
    .exm_wen(bus.exm_wen), .exm_rd(bus.exm_rd), .exm_data(bus.exm_data),
    .mem_wen(bus.mem_wen), .mem_rd(bus.mem_rd), .mem_data(bus.mem_data),
    .operand(op2)
  );

  // Stage registers: hold freezes; flush/hazard/invalid capture fields but mark a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_funct_q <= '0;
      ex_shamt_q <= '0;
      ex_r1_q    <= '0;
      ex_r2_q    <= '0;
      ex_imm_q   <= '0;
      ex_rd_q    <= '0;
      ex_wen_q   <= 1'b0;
      ex_ld_q    <= 1'b0;
    end else if (!bus.hold) begin
      ex_valid_q <= !kill;
      ex_op_q    <= ins.op;
      ex_funct_q <= ins.funct;
      ex_shamt_q <= ins.shamt;
      ex_r1_q    <= op1;
      ex_r2_q    <= op2;
      ex_imm_q   <= {{(DW-IMM_W){bus.id_instr[IMM_W-1]}}, bus.id_instr[IMM_W-1:0]};
      ex_rd_q    <= dest;
      ex_wen_q   <= wen_c && !kill;
      ex_ld_q    <= (ins.op == OP_LD);
    end
  end

  // Saturating load-use bubble counter; a flush takes priority over the hazard
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bcnt_q <= '0;
    else if (!bus.hold && !bus.flush && hazard && (bcnt_q != 16'hFFFF))
      bcnt_q <= bcnt_q + 16'd1;
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_op       = ex_op_q;
  assign bus.ex_funct    = ex_funct_q;
  assign bus.ex_shamt    = ex_shamt_q;
  assign bus.ex_reg1data = ex_r1_q;
  assign bus.ex_reg2data = ex_r2_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.ex_wen      = ex_wen_q;
  assign bus.ex_is_load  = ex_ld_q;
  assign bus.bubble_cnt  = bcnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a reference model.
module tb_id_ex_stage;
  import nq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();

  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  // Behavioural register file (write-through, combinational read)
  logic [15:0] rf [8];
  assign bus.rf_rdata1 = rf[bus.rf_raddr1];
  assign bus.rf_rdata2 = rf[bus.rf_raddr2];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the execute-side state
  logic        m_v, m_wen, m_ld;
  logic [1:0]  m_op, m_sh;
  logic [2:0]  m_fn, m_rd;
  logic [15:0] m_r1, m_r2, m_imm;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] resolve(input logic [2:0] a);
    if (a == 3'd0) return 16'h0;
    if (bus.exm_wen && bus.exm_rd == a) return bus.exm_data;
    if (bus.mem_wen && bus.mem_rd == a) return bus.mem_data;
    return rf[a];
  endfunction

  function automatic logic model_hazard();
    logic [2:0] rs, rt;
    rs = bus.id_instr[13:11];
    rt = bus.id_instr[10:8];
    return m_v && m_ld && m_wen && bus.id_valid && (m_rd == rs || m_rd == rt);
  endfunction

  task automatic model_reset();
    m_v = 0; m_wen = 0; m_ld = 0; m_op = 0; m_sh = 0; m_fn = 0; m_rd = 0;
    m_r1 = 0; m_r2 = 0; m_imm = 0; m_cnt = 0;
  endtask

  task automatic check_outs();
    chk("ex_valid", bus.ex_valid, m_v);
    chk("ex_wen", bus.ex_wen, m_wen);
    chk("bubble_cnt", bus.bubble_cnt, m_cnt);
    if (m_v) begin
      chk("ex_op", bus.ex_op, m_op);
      chk("ex_funct", bus.ex_funct, m_fn);
      chk("ex_shamt", bus.ex_shamt, m_sh);
      chk("ex_reg1data", bus.ex_reg1data, m_r1);
      chk("ex_reg2data", bus.ex_reg2data, m_r2);
      chk("ex_imm", bus.ex_imm, m_imm);
      chk("ex_rd", bus.ex_rd, m_rd);
      chk("ex_is_load", bus.ex_is_load, m_ld);
    end
  endtask

  // One clock: inputs already driven; check combinational outputs, advance model, check registers
  task automatic cycle();
    logic hz, kill;
    logic [1:0]  op;
    logic [2:0]  rs, rt, rd, dst;
    logic [15:0] n_r1, n_r2;
    #3;
    hz = model_hazard();
    chk("id_stall", bus.id_stall, hz || bus.hold);
    chk("rf_raddr1", bus.rf_raddr1, bus.id_instr[13:11]);
    chk("rf_raddr2", bus.rf_raddr2, bus.id_instr[10:8]);
    op = bus.id_instr[15:14];
    rs = bus.id_instr[13:11];
    rt = bus.id_instr[10:8];
    rd = bus.id_instr[7:5];
    n_r1 = resolve(rs);
    n_r2 = resolve(rt);
    kill = bus.flush || hz || !bus.id_valid;
    @(posedge clk);
    if (!bus.hold) begin
      dst   = (op == 2'b00) ? rd : rt;
      m_op  = op;
      m_fn  = bus.id_instr[2:0];
      m_sh  = bus.id_instr[4:3];
      m_rd  = dst;
      m_r1  = n_r1;
      m_r2  = n_r2;
      m_imm = {{8{bus.id_instr[7]}}, bus.id_instr[7:0]};
      m_ld  = (op == 2'b10);
      m_v   = !kill;
      m_wen = !kill && op != 2'b11 && dst != 3'd0;
      if (!bus.flush && hz && m_cnt < 65535) m_cnt++;
    end
    #1;
    check_outs();
  endtask

  task automatic clear_fwd();
    bus.exm_wen = 0; bus.exm_rd = 0; bus.exm_data = 0;
    bus.mem_wen = 0; bus.mem_rd = 0; bus.mem_data = 0;
  endtask

  function automatic logic [15:0] mk(input logic [1:0] op, input logic [2:0] rs, input logic [2:0] rt,
                                     input logic [2:0] rd, input logic [1:0] sh, input logic [2:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
    bus.id_instr = 0; bus.id_valid = 0; bus.hold = 0; bus.flush = 0;
    clear_fwd();
    model_reset();

    // Reset state
    #2;
    check_outs();
    @(posedge clk); #1;
    rst = 0;

    // R-type ADD r3 = r1 + r2
    rf[1] = 16'h0005; rf[2] = 16'h0003;
    bus.id_instr = mk(OP_R, 3'd1, 3'd2, 3'd3, 2'd0, 3'b101);
    bus.id_valid = 1;
    cycle();
    chk("add_r1", bus.ex_reg1data, 16'h0005);
    chk("add_r2", bus.ex_reg2data, 16'h0003);
    chk("add_funct", bus.ex_funct, 3'b101);
    chk("add_rd", bus.ex_rd, 3'd3);
    chk("add_wen", bus.ex_wen, 1'b1);

    // Forwarding priority
    bus.id_instr = mk(OP_R, 3'd1, 3'd0, 3'd2, 2'd1, 3'b000);
    bus.exm_wen = 1; bus.exm_rd = 3'd1; bus.exm_data = 16'h00AA;
    bus.mem_wen = 1; bus.mem_rd = 3'd1; bus.mem_data = 16'h0055;
    cycle();
    chk("fwd_exm", bus.ex_reg1data, 16'h00AA);
    bus.exm_wen = 0;
    cycle();
    chk("fwd_mem", bus.ex_reg1data, 16'h0055);
    rf[0] = 16'hDEAD;
    bus.id_instr = mk(OP_I, 3'd0, 3'd0, 3'd0, 2'd0, 3'b001);
    bus.exm_wen = 1; bus.exm_rd = 3'd0; bus.exm_data = 16'h0077;
    bus.mem_wen = 1; bus.mem_rd = 3'd0; bus.mem_data = 16'h0066;
    cycle();
    chk("fwd_r0_1", bus.ex_reg1data, 16'h0000);
    chk("fwd_r0_2", bus.ex_reg2data, 16'h0000);
    chk("r0_nowen", bus.ex_wen, 1'b0);

    // Load-use: LD r4 then ADD using r4
    clear_fwd();
    bus.id_instr = mk(OP_LD, 3'd1, 3'd4, 3'd0, 2'd0, 3'b100);
    cycle();
    bus.id_instr = mk(OP_R, 3'd4, 3'd2, 3'd5, 2'd0, 3'b101);
    #1 chk("lu_stall", bus.id_stall, 1'b1);
    cycle();
    chk("lu_bubble", bus.ex_valid, 1'b0);
    chk("lu_cnt", bus.bubble_cnt, 16'd1);
    bus.mem_wen = 1; bus.mem_rd = 3'd4; bus.mem_data = 16'h1234;
    #1 chk("lu_nostall", bus.id_stall, 1'b0);
    cycle();
    chk("lu_fwd", bus.ex_reg1data, 16'h1234);
    chk("lu_valid", bus.ex_valid, 1'b1);
    clear_fwd();

    // Hold for three cycles with changing inputs
    bus.hold = 1;
    for (int i = 0; i < 3; i++) begin
      bus.id_instr = 16'($urandom);
      rf[2] = 16'($urandom);
      cycle();
      chk("hold_r1", bus.ex_reg1data, 16'h1234);
    end
    bus.flush = 1;
    cycle();
    chk("hold_flush", bus.ex_valid, 1'b1);
    bus.hold = 0;
    cycle();
    chk("flush", bus.ex_valid, 1'b0);
    bus.flush = 0;

    // Saturation: preload near the ceiling, then three hazards
    bus.hold = 1;
    force dut.bcnt_q = 16'hFFFE;
    #1 release dut.bcnt_q;
    m_cnt = 65534;
    cycle();
    bus.hold = 0;
    for (int k = 0; k < 3; k++) begin
      bus.id_instr = mk(OP_LD, 3'd1, 3'd4, 3'd0, 2'd0, 3'b000);
      cycle();
      bus.id_instr = mk(OP_R, 3'd4, 3'd2, 3'd5, 2'd0, 3'b101);
      cycle();
    end
    chk("sat", bus.bubble_cnt, 16'hFFFF);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic keep;
      keep = bus.id_stall && ($urandom_range(0, 9) < 7);
      if (!keep) begin
        bus.id_instr = mk(2'($urandom), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)),
                          3'($urandom_range(0, 4)), 2'($urandom), 3'($urandom));
        bus.id_instr[7:0] = 8'($urandom);
        bus.id_instr[7:5] = 3'($urandom_range(0, 4));
      end
      bus.id_valid = ($urandom_range(0, 9) != 0);
      bus.hold     = ($urandom_range(0, 9) == 0);
      bus.flush    = ($urandom_range(0, 9) == 0);
      bus.exm_wen  = 1'($urandom);  bus.exm_rd = 3'($urandom_range(0, 4)); bus.exm_data = 16'($urandom);
      bus.mem_wen  = 1'($urandom);  bus.mem_rd = 3'($urandom_range(0, 4)); bus.mem_data = 16'($urandom);
      rf[$urandom_range(0, 7)] = 16'($urandom);
      cycle();
    end

    // Asynchronous reset mid-stream
    @(posedge clk); #3;
    rst = 1;
    #1;
    model_reset();
    check_outs();
    @(posedge clk); #1;
    check_outs();
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
